rib_arbiter: RTL and testbench

RIB_ARBITER -- requirements
Module: rib_arbiter

---
 rtl/rib_arbiter.sv | 131 +++++++++++++
 tb/tb_rib_arbiter.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/rib_arbiter.sv
// Six-master bus arbiter: JTAG > data > fetch class priority, round-robin
// between the two cores inside a class, and burst locking for the current owner.
module rib_arbiter #(
    parameter int BURST_MAX = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] req_i,
    output logic [5:0] gnt_o,
    output logic [2:0] gnt_idx_o,
    output logic       gnt_valid_o,
    output logic       hold_flag_o_0,
    output logic       hold_flag_o_1
);

    localparam logic [2:0] IDX_NONE = 3'd7;
    localparam logic [3:0] CNT_LAST = 4'(BURST_MAX - 1);

    localparam logic [1:0] CLS_FETCH = 2'd0;
    localparam logic [1:0] CLS_DATA  = 2'd1;
    localparam logic [1:0] CLS_JTAG  = 2'd2;
    localparam logic [1:0] CLS_NONE  = 2'd3;

    logic [2:0] owner;
    logic [3:0] burst_cnt;
    logic       ptr_jtag;
    logic       ptr_data;
    logic       ptr_fetch;

    logic [5:0] owner_mask;
    logic [5:0] req_others;
    logic       owner_req;
    logic       higher_req;
    logic       lock;
    logic       expired;
    logic [2:0] grant_idx;

    function automatic logic [1:0] class_of(input logic [2:0] idx);
        case (idx)
            3'd2, 3'd5: class_of = CLS_JTAG;
            3'd0, 3'd3: class_of = CLS_DATA;
            3'd1, 3'd4: class_of = CLS_FETCH;
            default:    class_of = CLS_NONE;
        endcase
    endfunction

    // A set pointer means core1 was served last, so core0's member wins the tie.
    function automatic logic [2:0] pick_pair(input logic r_c0, input logic r_c1,
                                             input logic ptr,
                                             input logic [2:0] idx_c0,
                                             input logic [2:0] idx_c1);
        if (r_c0 && r_c1)
            pick_pair = ptr ? idx_c0 : idx_c1;
        else if (r_c0)
            pick_pair = idx_c0;
        else
            pick_pair = idx_c1;
    endfunction

    function automatic logic [2:0] pick(input logic [5:0] r, input logic pj,
                                        input logic pd, input logic pf);
        if (r[2] || r[5])
            pick = pick_pair(r[2], r[5], pj, 3'd2, 3'd5);
        else if (r[0] || r[3])
            pick = pick_pair(r[0], r[3], pd, 3'd0, 3'd3);
        else if (r[1] || r[4])
            pick = pick_pair(r[1], r[4], pf, 3'd1, 3'd4);
        else
            pick = IDX_NONE;
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] c);
        if (c >= CNT_LAST)
            sat_inc = CNT_LAST;
        else
            sat_inc = c + 4'd1;
    endfunction

    always_comb begin
        owner_mask = (owner < 3'd6) ? (6'd1 << owner) : 6'd0;
        owner_req  = |(req_i & owner_mask);
        req_others = req_i & ~owner_mask;

        higher_req = 1'b0;
        case (class_of(owner))
            CLS_DATA:  higher_req = req_i[2] | req_i[5];
            CLS_FETCH: higher_req = req_i[2] | req_i[5] | req_i[0] | req_i[3];
            default:   higher_req = 1'b0;
        endcase

        lock    = owner_req && !higher_req && (burst_cnt < CNT_LAST);
        expired = owner_req && (burst_cnt >= CNT_LAST);

        // An expired owner yields to anyone else; alone, it simply wins fresh arbitration.
        if (lock)
            grant_idx = owner;
        else if (expired && (|req_others))
            grant_idx = pick(req_others, ptr_jtag, ptr_data, ptr_fetch);
        else
            grant_idx = pick(req_i, ptr_jtag, ptr_data, ptr_fetch);
    end

    always_comb begin
        gnt_idx_o     = rst ? IDX_NONE : grant_idx;
        gnt_valid_o   = (gnt_idx_o != IDX_NONE);
        gnt_o         = gnt_valid_o ? (6'd1 << gnt_idx_o) : 6'd0;
        // JTAG traffic on a core's side stalls that core as well.
        hold_flag_o_0 = !rst && (req_i[0] | req_i[1] | req_i[2]) && !(gnt_o[0] | gnt_o[1]);
        hold_flag_o_1 = !rst && (req_i[3] | req_i[4] | req_i[5]) && !(gnt_o[3] | gnt_o[4]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner     <= IDX_NONE;
            burst_cnt <= 4'd0;
            ptr_jtag  <= 1'b1;
            ptr_data  <= 1'b1;
            ptr_fetch <= 1'b1;
        end else begin
            owner     <= grant_idx;
            burst_cnt <= lock ? sat_inc(burst_cnt) : 4'd0;
            case (class_of(grant_idx))
                CLS_JTAG:  ptr_jtag  <= (grant_idx >= 3'd3);
                CLS_DATA:  ptr_data  <= (grant_idx >= 3'd3);
                CLS_FETCH: ptr_fetch <= (grant_idx >= 3'd3);
                default:   ;
            endcase
        end
    end

endmodule

// File: tb/tb_rib_arbiter.sv
// Directed bench for rib_arbiter: one instance with BURST_MAX=4 and one with
// BURST_MAX=1, driven from the same clock, reset and request vector.
module tb_rib_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] req;

    logic [5:0] gnt4, gnt1;
    logic [2:0] idx4, idx1;
    logic       vld4, vld1;
    logic       h0_4, h1_4, h0_1, h1_1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rib_arbiter #(.BURST_MAX(4)) dut (
        .clk(clk), .rst(rst), .req_i(req),
        .gnt_o(gnt4), .gnt_idx_o(idx4), .gnt_valid_o(vld4),
        .hold_flag_o_0(h0_4), .hold_flag_o_1(h1_4)
    );

    rib_arbiter #(.BURST_MAX(1)) dut1 (
        .clk(clk), .rst(rst), .req_i(req),
        .gnt_o(gnt1), .gnt_idx_o(idx1), .gnt_valid_o(vld1),
        .hold_flag_o_0(h0_1), .hold_flag_o_1(h1_1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle just after the falling edge, check, then advance to the next falling edge.
    // e_cnt < 0 skips the burst counter check; use1 selects the BURST_MAX=1 instance.
    task automatic cyc(input string tag, input bit use1, input logic r, input logic [5:0] q,
                       input logic [2:0] e_idx, input logic e_h0, input logic e_h1,
                       input int e_cnt);
        logic [5:0] e_gnt;
        rst = r;
        req = q;
        #1;
        e_gnt = (e_idx == 3'd7) ? 6'd0 : (6'd1 << e_idx);
        check({tag, ".idx"}, use1 ? idx1 : idx4, e_idx);
        check({tag, ".gnt"}, use1 ? gnt1 : gnt4, e_gnt);
        check({tag, ".vld"}, use1 ? vld1 : vld4, (e_idx != 3'd7));
        check({tag, ".h0"},  use1 ? h0_1 : h0_4, e_h0);
        check({tag, ".h1"},  use1 ? h1_1 : h1_4, e_h1);
        if (e_cnt >= 0)
            check({tag, ".cnt"}, dut.burst_cnt, e_cnt);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 6'd0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req = 6'd0;
        @(negedge clk);

        // Reset forces idle outputs even with every request high.
        cyc("rst4", 1'b0, 1'b1, 6'b111111, 3'd7, 1'b0, 1'b0, 0);
        cyc("rst1", 1'b1, 1'b1, 6'b111111, 3'd7, 1'b0, 1'b0, -1);
        check("rst.owner", dut.owner, 3'd7);
        check("rst.ptr",   {dut.ptr_jtag, dut.ptr_data, dut.ptr_fetch}, 3'b111);

        // Both fetch ports with no locking: strict alternation 1,4,1,4.
        do_reset();
        cyc("rr1a", 1'b1, 1'b0, 6'b010010, 3'd1, 1'b0, 1'b1, -1);
        cyc("rr1b", 1'b1, 1'b0, 6'b010010, 3'd4, 1'b1, 1'b0, -1);
        cyc("rr1c", 1'b1, 1'b0, 6'b010010, 3'd1, 1'b0, 1'b1, -1);
        cyc("rr1d", 1'b1, 1'b0, 6'b010010, 3'd4, 1'b1, 1'b0, -1);

        // Both data ports, bursts of four: counter seen in the following cycle.
        do_reset();
        cyc("bd0", 1'b0, 1'b0, 6'b001001, 3'd0, 1'b0, 1'b1, 0);
        cyc("bd1", 1'b0, 1'b0, 6'b001001, 3'd0, 1'b0, 1'b1, 0);
        cyc("bd2", 1'b0, 1'b0, 6'b001001, 3'd0, 1'b0, 1'b1, 1);
        cyc("bd3", 1'b0, 1'b0, 6'b001001, 3'd0, 1'b0, 1'b1, 2);
        cyc("bd4", 1'b0, 1'b0, 6'b001001, 3'd3, 1'b1, 1'b0, 3);
        cyc("bd5", 1'b0, 1'b0, 6'b001001, 3'd3, 1'b1, 1'b0, 0);
        cyc("bd6", 1'b0, 1'b0, 6'b001001, 3'd3, 1'b1, 1'b0, 1);
        cyc("bd7", 1'b0, 1'b0, 6'b001001, 3'd3, 1'b1, 1'b0, 2);
        cyc("bd8", 1'b0, 1'b0, 6'b001001, 3'd0, 1'b0, 1'b1, 3);

        // JTAG1 preempts a core0 data burst at once, then data resumes.
        do_reset();
        cyc("pre0", 1'b0, 1'b0, 6'b000001, 3'd0, 1'b0, 1'b0, 0);
        cyc("pre1", 1'b0, 1'b0, 6'b000001, 3'd0, 1'b0, 1'b0, 0);
        cyc("pre2", 1'b0, 1'b0, 6'b100001, 3'd5, 1'b1, 1'b1, 1);
        cyc("pre3", 1'b0, 1'b0, 6'b100001, 3'd5, 1'b1, 1'b1, 0);
        cyc("pre4", 1'b0, 1'b0, 6'b000001, 3'd0, 1'b0, 1'b0, 1);

        // Both JTAG ports: locked bursts alternate, both cores stalled throughout.
        do_reset();
        for (int i = 0; i < 9; i++)
            cyc($sformatf("jt%0d", i), 1'b0, 1'b0, 6'b100100,
                ((i >= 4) && (i < 8)) ? 3'd5 : 3'd2, 1'b1, 1'b1, -1);

        // Reset pulse in the middle of a core1 data burst.
        do_reset();
        for (int i = 0; i < 4; i++)
            cyc($sformatf("mr%0d", i), 1'b0, 1'b0, 6'b001001, 3'd0, 1'b0, 1'b1, -1);
        cyc("mr4", 1'b0, 1'b0, 6'b001001, 3'd3, 1'b1, 1'b0, 3);
        cyc("mr5", 1'b0, 1'b0, 6'b001001, 3'd3, 1'b1, 1'b0, 0);
        cyc("mr6", 1'b0, 1'b1, 6'b001001, 3'd7, 1'b0, 1'b0, 1);
        cyc("mr7", 1'b0, 1'b0, 6'b001001, 3'd0, 1'b0, 1'b1, 0);

        // Lone requester: continuous grant, counter restarts with no gap.
        do_reset();
        cyc("lone0", 1'b0, 1'b0, 6'b000001, 3'd0, 1'b0, 1'b0, 0);
        for (int i = 1; i < 10; i++)
            cyc($sformatf("lone%0d", i), 1'b0, 1'b0, 6'b000001, 3'd0, 1'b0, 1'b0, (i - 1) % 4);

        // Requests drop to zero: idle outputs, owner released.
        cyc("idle0", 1'b0, 1'b0, 6'b000000, 3'd7, 1'b0, 1'b0, -1);
        check("idle.owner", dut.owner, 3'd7);
        check("idle.cnt",   dut.burst_cnt, 4'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

endmodule
